// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO issuing one operation at a time to a fixed-latency ALU
module alu_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [7:0] cmd_op,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [7:0] op,
    input  logic [7:0] alu_c,
    input  logic [3:0] alu_flags,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_c,
    output logic [3:0] res_flags,
    output logic       busy,
    output logic [7:0] done_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

    state_e        state_q, state_d;
    logic [23:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ready_en_q;
    logic [2:0]    lat_cnt_q, lat_cnt_d;
    logic [7:0]    a_q, a_d, b_q, b_d, op_q, op_d;
    logic [7:0]    res_c_q, res_c_d;
    logic [3:0]    res_flags_q, res_flags_d;
    logic [7:0]    done_q, done_d;
    logic          push, pop, capture, retire;

    // ready_en_q keeps cmd_ready low during reset and up from the first edge after release
    assign cmd_ready = ready_en_q && (count_q < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign capture   = (state_q == WAIT) && (lat_cnt_q == 3'(ALU_LATENCY));
    assign retire    = (state_q == HOLD) && res_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_en_q  <= 1'b0;
            lat_cnt_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_c_q     <= '0;
            res_flags_q <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_q    <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
            count_q     <= count_d;
            ready_en_q  <= 1'b1;
            lat_cnt_q   <= lat_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_c_q     <= res_c_d;
            res_flags_q <= res_flags_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = WAIT;
            WAIT:    if (capture) state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // lat_cnt_q counts edges since issue; the result is sampled when it reaches ALU_LATENCY
    always_comb begin
        lat_cnt_d   = lat_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_c_d     = res_c_q;
        res_flags_d = res_flags_q;
        done_d      = done_q;
        if (pop) begin
            {op_d, b_d, a_d} = mem_q[rd_ptr_q];
            lat_cnt_d        = '0;
        end
        if (state_q == WAIT) begin
            lat_cnt_d = lat_cnt_q + 3'd1;
        end
        if (capture) begin
            res_c_d     = alu_c;
            res_flags_d = alu_flags;
        end
        if (retire) begin
            done_d = done_q + 8'd1;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        res_valid = (state_q == HOLD);
    end

    assign a          = a_q;
    assign b          = b_q;
    assign op         = op_q;
    assign res_c      = res_c_q;
    assign res_flags  = res_flags_q;
    assign done_count = done_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized and directed bench with a queue-based reference model
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0, cmd_b = '0, cmd_op = '0;
    logic [7:0] a, b, op;
    logic [7:0] alu_c;
    logic [3:0] alu_flags;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_c;
    logic [3:0] res_flags;
    logic       busy;
    logic [7:0] done_count;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .a(a), .b(b), .op(op),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_c(res_c), .res_flags(res_flags),
        .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    // ALU stub: registered adder, LAT edges from operands to result, carry in flags[0]
    logic [8:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= {1'b0, a} + {1'b0, b};
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_c     = alu_pipe[LAT-1][7:0];
    assign alu_flags = {3'b000, alu_pipe[LAT-1][8]};

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: queue of pending commands plus age of the one in flight
    typedef struct packed { logic [7:0] a, b, op; } cmd_t;
    cmd_t       fifo_m[$];
    cmd_t       head_m;
    int         age_m = -1;
    bit         started_m = 0;
    bit         push_m;
    logic [7:0] ma = '0, mb = '0, mop = '0, mc = '0;
    logic [3:0] mf = '0;
    logic [8:0] msum;
    int         total_done = 0;
    int         cyc = 0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            fifo_m.delete();
            age_m = -1; started_m = 0; total_done = 0;
            ma = '0; mb = '0; mop = '0; mc = '0; mf = '0;
        end else begin
            cyc++;
            push_m = started_m && (fifo_m.size() < DEPTH) && cmd_valid;
            if (age_m < 0) begin
                if (fifo_m.size() > 0) begin
                    head_m = fifo_m.pop_front();
                    ma = head_m.a; mb = head_m.b; mop = head_m.op;
                    age_m = 0;
                end
            end else if (age_m <= LAT) begin
                age_m++;
                if (age_m == LAT + 1) begin
                    msum = {1'b0, ma} + {1'b0, mb};
                    mc = msum[7:0];
                    mf = {3'b000, msum[8]};
                end
            end else if (res_ready) begin
                total_done++;
                age_m = -1;
            end
            if (push_m) fifo_m.push_back('{a: cmd_a, b: cmd_b, op: cmd_op});
            started_m = 1;
        end
    end

    bit chk_en = 0;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cmd_ready", int'(cmd_ready), int'(started_m && fifo_m.size() < DEPTH));
            check("a", int'(a), int'(ma));
            check("b", int'(b), int'(mb));
            check("op", int'(op), int'(mop));
            check("busy", int'(busy), int'(age_m >= 0));
            check("res_valid", int'(res_valid), int'(age_m == LAT + 1));
            check("res_c", int'(res_c), int'(mc));
            check("res_flags", int'(res_flags), int'(mf));
            check("done_count", int'(done_count), total_done % 256);
        end
    end

    typedef struct { int cyc; logic [7:0] c; logic [3:0] f; } hs_t;
    hs_t hs_q[$];
    bit  thr_mon = 0;
    initial forever begin
        @(negedge clk);
        if (thr_mon && res_valid) hs_q.push_back('{cyc: cyc, c: res_c, f: res_flags});
    end

    task automatic push(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] opv);
        int n = 0;
        cmd_a = av; cmd_b = bv; cmd_op = opv; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    int thr_c[4] = '{30, 3, 0, 0};
    int thr_f[4] = '{0, 0, 1, 0};
    bit wrapped = 0;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset_cmd_ready", int'(cmd_ready), 0);
        reset = 1'b1;
        @(negedge clk);

        // single command with a carry out
        push(8'd255, 8'd1, 8'd0);
        @(negedge clk);
        check("single_a", int'(a), 255);
        check("single_b", int'(b), 1);
        check("single_op", int'(op), 0);
        @(negedge clk);
        check("single_early_valid", int'(res_valid), 0);
        @(negedge clk);
        check("single_res_valid", int'(res_valid), 1);
        check("single_res_c", int'(res_c), 0);
        check("single_res_flags", int'(res_flags), 1);
        repeat (10) @(negedge clk);
        check("bp_busy", int'(busy), 1);
        check("bp_res_c", int'(res_c), 0);
        check("bp_a", int'(a), 255);
        res_ready = 1'b1;
        @(negedge clk);
        check("single_done", int'(done_count), 1);
        check("single_valid_clear", int'(res_valid), 0);
        res_ready = 1'b0;

        // fill to full: one issued, four queued
        for (int i = 0; i < 5; i++) push(8'(i + 1), 8'(i * 3), 8'(i));
        check("full_ready", int'(cmd_ready), 0);
        cmd_a = 8'd77; cmd_b = 8'd88; cmd_op = 8'd5; cmd_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("full_held", int'(cmd_ready), 0);
        res_ready = 1'b1;
        push(8'd77, 8'd88, 8'd5);
        repeat (40) @(negedge clk);
        check("drain_idle", int'(busy), 0);

        // throughput with res_ready held high
        thr_mon = 1;
        push(8'd10, 8'd20, 8'd0);
        push(8'd1, 8'd2, 8'd0);
        push(8'd128, 8'd128, 8'd0);
        push(8'd0, 8'd0, 8'd0);
        repeat (25) @(negedge clk);
        thr_mon = 0;
        check("thr_count", hs_q.size(), 4);
        for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
            check("thr_res_c", int'(hs_q[i].c), thr_c[i]);
            check("thr_res_flags", int'(hs_q[i].f), thr_f[i]);
            if (i > 0) check("thr_spacing", hs_q[i].cyc - hs_q[i-1].cyc, LAT + 3);
        end

        // reset while waiting on the ALU with two commands queued
        res_ready = 1'b0;
        push(8'd1, 8'd1, 8'd0);
        push(8'd2, 8'd2, 8'd0);
        push(8'd3, 8'd3, 8'd0);
        check("rst_pre_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_a", int'(a), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_done", int'(done_count), 0);
        check("rst_res_c", int'(res_c), 0);
        @(negedge clk);
        reset = 1'b1;
        res_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_after_done", int'(done_count), 0);
        check("rst_after_busy", int'(busy), 0);

        // random traffic until 256 completions wrap done_count
        for (int n = 0; n < 20000 && !wrapped; n++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 8'($urandom);
            res_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (total_done == 256) begin
                check("wrap_done", int'(done_count), 0);
                wrapped = 1;
            end
        end
        check("wrap_reached", int'(wrapped), 1);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
